// File: rtl/id_operand_stage_pkg.sv
// Shared defaults and constants for the operand-fetch / interlock stage:
// data/address widths, the NOP register, the zero word and decode-control field offsets.
package id_operand_stage_pkg;

   localparam int DEF_DW     = 32;
   localparam int DEF_AW     = 5;
   localparam int DEF_CTRL_W = 24;

   localparam logic [DEF_AW-1:0] NOP_REG_ADDR = '0;
   localparam logic [DEF_DW-1:0] ZERO_WORD    = '0;
   localparam logic              READ_ENABLE  = 1'b1;
   localparam logic              READ_DISABLE = 1'b0;

   // Layout of the opaque control bundle; this stage only carries it through.
   localparam int CTRL_ALUOP_LSB  = 0;
   localparam int CTRL_ALUOP_W    = 8;
   localparam int CTRL_ALUSEL_LSB = 8;
   localparam int CTRL_ALUSEL_W   = 3;
   localparam int CTRL_WADDR_LSB  = 11;
   localparam int CTRL_WREG_BIT   = 16;

   function automatic logic [DEF_AW-1:0] ctrl_waddr(input logic [DEF_CTRL_W-1:0] ctrl);
      return ctrl[CTRL_WADDR_LSB +: DEF_AW];
   endfunction

endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// One read port's operand mux: immediate / zero register / youngest-first forwarding / register file,
// plus the load-use hazard flag for that port.
module id_operand_stage_fwd_select
   import id_operand_stage_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int AW       = DEF_AW,
   parameter int NFS      = 2,
   parameter bit IS_IMM   = 1'b0,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              rden,
   input  logic [AW-1:0]     raddr,
   input  logic [DW-1:0]     imm,
   input  logic [DW-1:0]     rf_rdata,
   input  logic [NFS-1:0]    fwd_wen,
   input  logic [NFS*AW-1:0] fwd_waddr,
   input  logic [NFS*DW-1:0] fwd_wdata,
   input  logic [NFS-1:0]    fwd_rdy,
   output logic [DW-1:0]     opnd,
   output logic              hazard
);

   always_comb begin
      opnd   = rf_rdata;
      hazard = 1'b0;
      if (rden == READ_DISABLE) begin
         opnd = IS_IMM ? imm : DW'(ZERO_WORD);
      end else if (ZERO_REG && (raddr == AW'(NOP_REG_ADDR))) begin
         opnd = DW'(ZERO_WORD);
      end else begin
         // Walk oldest to youngest so the youngest match is the last assignment and wins,
         // including its ready flag: an older ready result never masks a younger pending load.
         for (int k = NFS - 1; k >= 0; k--) begin
            if (fwd_wen[k] && (fwd_waddr[k*AW +: AW] == raddr)) begin
               opnd   = fwd_wdata[k*DW +: DW];
               hazard = !fwd_rdy[k];
            end
         end
      end
   end

endmodule

// File: rtl/id_operand_stage.sv
// Operand fetch and interlock stage between decode and EX, with an ID/EX output register.
// Optional build macro ID_STALL_CNT_EN adds a saturating load-use stall counter output.
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int AW       = DEF_AW,
   parameter int NRP      = 2,
   parameter int NFS      = 2,
   parameter int CTRL_W   = DEF_CTRL_W,
   parameter int IMM_PORT = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NRP-1:0]    in_rden,
   input  logic [NRP*AW-1:0] in_raddr,
   input  logic [DW-1:0]     in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [NRP*DW-1:0] rf_rdata,
   input  logic [NFS-1:0]    fwd_wen,
   input  logic [NFS*AW-1:0] fwd_waddr,
   input  logic [NFS*DW-1:0] fwd_wdata,
   input  logic [NFS-1:0]    fwd_rdy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NRP*DW-1:0] out_opnd,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef ID_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   logic [NRP*DW-1:0] sel_opnd;
   logic [NRP-1:0]    port_hazard;
   logic              hazard;
   logic              accept;

   for (genvar p = 0; p < NRP; p++) begin : g_port
      id_operand_stage_fwd_select #(
         .DW       (DW),
         .AW       (AW),
         .NFS      (NFS),
         .IS_IMM   (p == IMM_PORT),
         .ZERO_REG (ZERO_REG != 0)
      ) u_sel (
         .rden      (in_rden[p]),
         .raddr     (in_raddr[p*AW +: AW]),
         .imm       (in_imm),
         .rf_rdata  (rf_rdata[p*DW +: DW]),
         .fwd_wen   (fwd_wen),
         .fwd_waddr (fwd_waddr),
         .fwd_wdata (fwd_wdata),
         .fwd_rdy   (fwd_rdy),
         .opnd      (sel_opnd[p*DW +: DW]),
         .hazard    (port_hazard[p])
      );
   end

   assign hazard = |port_hazard;

   // Handshake: a bundle moves when valid && ready on the same rising edge. in_ready never
   // depends on in_valid; out_valid, once high, stays high with stable data until out_ready.
   assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_opnd  <= '0;
         out_ctrl  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_opnd  <= sel_opnd;
         out_ctrl  <= in_ctrl;
      end else if (out_ready) begin
         // Consumed with nothing new behind it: a bubble, e.g. while a load is pending.
         out_valid <= 1'b0;
      end
   end

`ifdef ID_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (in_valid && hazard && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: forwarding priority, load-use interlock,
// immediate/zero register, backpressure, flush and reset, checked against hand-computed bundles.
module tb_id_operand_stage;

   localparam int DW     = 32;
   localparam int AW     = 5;
   localparam int NRP    = 2;
   localparam int NFS    = 2;
   localparam int CTRL_W = 24;
   localparam int BW     = CTRL_W + NRP*DW;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [NRP-1:0]    in_rden;
   logic [NRP*AW-1:0] in_raddr;
   logic [DW-1:0]     in_imm;
   logic [CTRL_W-1:0] in_ctrl;
   logic [NRP*DW-1:0] rf_rdata;
   logic [NFS-1:0]    fwd_wen;
   logic [NFS*AW-1:0] fwd_waddr;
   logic [NFS*DW-1:0] fwd_wdata;
   logic [NFS-1:0]    fwd_rdy;
   logic              out_valid;
   logic              out_ready;
   logic [NRP*DW-1:0] out_opnd;
   logic [CTRL_W-1:0] out_ctrl;
`ifdef ID_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] last_bundle;
   int            n_vec;
   int            n_bad;

   id_operand_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rden   (in_rden),
      .in_raddr  (in_raddr),
      .in_imm    (in_imm),
      .in_ctrl   (in_ctrl),
      .rf_rdata  (rf_rdata),
      .fwd_wen   (fwd_wen),
      .fwd_waddr (fwd_waddr),
      .fwd_wdata (fwd_wdata),
      .fwd_rdy   (fwd_rdy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_opnd  (out_opnd),
      .out_ctrl  (out_ctrl)
`ifdef ID_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_instr(input logic [1:0] rden, input logic [AW-1:0] ra1, input logic [AW-1:0] ra0,
                              input logic [DW-1:0] imm, input logic [DW-1:0] rf1, input logic [DW-1:0] rf0,
                              input logic [CTRL_W-1:0] ctrl);
      in_valid = 1'b1;
      in_rden  = rden;
      in_raddr = {ra1, ra0};
      in_imm   = imm;
      rf_rdata = {rf1, rf0};
      in_ctrl  = ctrl;
   endtask

   task automatic set_fwd(input int k, input logic wen, input logic [AW-1:0] waddr,
                          input logic [DW-1:0] wdata, input logic rdy);
      fwd_wen[k]              = wen;
      fwd_waddr[k*AW +: AW]   = waddr;
      fwd_wdata[k*DW +: DW]   = wdata;
      fwd_rdy[k]              = rdy;
   endtask

   task automatic expect_bundle(input logic [CTRL_W-1:0] ctrl, input logic [DW-1:0] op1, input logic [DW-1:0] op0);
      exp_q.push_back({ctrl, op1, op0});
   endtask

   // scoreboard: the bundle now on the output must be the oldest expected one
   task automatic check_pop(input string tag);
      logic [BW-1:0] e;
      check({tag, "_valid"}, BW'(out_valid), BW'(1));
      check({tag, "_qdepth"}, BW'(exp_q.size()), BW'(1));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_bundle"}, {out_ctrl, out_opnd}, e);
         last_bundle = e;
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      last_bundle = '0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_rden = '0; in_raddr = '0; in_imm = '0; in_ctrl = '0; rf_rdata = '0;
      fwd_wen = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_rdy = '0;
      tick();
      tick();
      check("rst_valid", BW'(out_valid), BW'(0));
      check("rst_bundle", {out_ctrl, out_opnd}, BW'(0));
      check("rst_in_ready", BW'(in_ready), BW'(0));
`ifdef ID_STALL_CNT_EN
      check("rst_stall_cnt", BW'(stall_cnt), BW'(0));
`endif
      rst = 1'b0;
      #1;
      check("idle_in_ready", BW'(in_ready), BW'(1));

      // no dependency: register-file data on both ports
      out_ready = 1'b1;
      drive_instr(2'b11, 5'd2, 5'd1, 32'h0, 32'h22, 32'h11, 24'h000101);
      #1;
      check("nodep_in_ready", BW'(in_ready), BW'(1));
      expect_bundle(24'h000101, 32'h22, 32'h11);
      tick();
      check_pop("nodep");

      // youngest-first: EX and MEM both write r3, both ports read r3
      drive_instr(2'b11, 5'd3, 5'd3, 32'h0, 32'h33, 32'h33, 24'h000202);
      set_fwd(0, 1'b1, 5'd3, 32'hAA, 1'b1);
      set_fwd(1, 1'b1, 5'd3, 32'hBB, 1'b1);
      #1;
      check("youngest_in_ready", BW'(in_ready), BW'(1));
      expect_bundle(24'h000202, 32'hAA, 32'hAA);
      tick();
      check_pop("youngest");

      // EX writes a different register: MEM result wins over the register file
      set_fwd(0, 1'b1, 5'd7, 32'hAA, 1'b1);
      in_ctrl = 24'h000303;
      expect_bundle(24'h000303, 32'hBB, 32'hBB);
      tick();
      check_pop("older_fwd");

      // load-use: EX has r4 pending, MEM has a ready r4 that must not override it
      drive_instr(2'b11, 5'd2, 5'd4, 32'h0, 32'h22, 32'h40, 24'h000404);
      set_fwd(0, 1'b1, 5'd4, 32'h44, 1'b0);
      set_fwd(1, 1'b1, 5'd4, 32'h55, 1'b1);
      #1;
      check("lu_in_ready_c1", BW'(in_ready), BW'(0));
      tick();
      check("lu_bubble_c1", BW'(out_valid), BW'(0));
      check("lu_in_ready_c2", BW'(in_ready), BW'(0));
      tick();
      check("lu_bubble_c2", BW'(out_valid), BW'(0));
      set_fwd(0, 1'b0, 5'd0, 32'h0, 1'b0);
      #1;
      check("lu_in_ready_c3", BW'(in_ready), BW'(1));
      expect_bundle(24'h000404, 32'h22, 32'h55);
      tick();
      check_pop("lu_accept");
`ifdef ID_STALL_CNT_EN
      check("lu_stall_cnt", BW'(stall_cnt), BW'(2));
`endif

      // immediate on port 1, zero register on port 0 even though EX writes r0 (not ready)
      drive_instr(2'b01, 5'd9, 5'd0, 32'h1F, 32'h99, 32'hDEAD, 24'h000505);
      set_fwd(0, 1'b1, 5'd0, 32'hFF, 1'b0);
      set_fwd(1, 1'b0, 5'd0, 32'h0, 1'b0);
      #1;
      check("imm_in_ready", BW'(in_ready), BW'(1));
      expect_bundle(24'h000505, 32'h1F, 32'h0);
      tick();
      check_pop("imm_zero");

      // port 0 disabled reads 0, port 1 reads the register file
      drive_instr(2'b10, 5'd5, 5'd6, 32'h1F, 32'h5555, 32'h6666, 24'h000606);
      set_fwd(0, 1'b0, 5'd0, 32'h0, 1'b0);
      expect_bundle(24'h000606, 32'h5555, 32'h0);
      tick();
      check_pop("rden_off");

      // backpressure: three stalled cycles, outputs frozen, new instruction waiting
      out_ready = 1'b0;
      drive_instr(2'b11, 5'd8, 5'd7, 32'h0, 32'h66, 32'h77, 24'h000707);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp_in_ready_%0d", i), BW'(in_ready), BW'(0));
         tick();
         check($sformatf("bp_valid_%0d", i), BW'(out_valid), BW'(1));
         check($sformatf("bp_bundle_%0d", i), {out_ctrl, out_opnd}, last_bundle);
      end

      // flush: drops the held bundle and accepts nothing that cycle
      flush = 1'b1;
      #1;
      check("flush_in_ready", BW'(in_ready), BW'(0));
      tick();
      check("flush_valid", BW'(out_valid), BW'(0));
      check("flush_hold", {out_ctrl, out_opnd}, last_bundle);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("post_flush_valid", BW'(out_valid), BW'(0));

      // reset while a bundle is valid
      drive_instr(2'b11, 5'd10, 5'd11, 32'h0, 32'hAB, 32'hCD, 24'h000808);
      expect_bundle(24'h000808, 32'hAB, 32'hCD);
      tick();
      check_pop("pre_rst");
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      check("midrst_valid", BW'(out_valid), BW'(0));
      check("midrst_bundle", {out_ctrl, out_opnd}, BW'(0));
`ifdef ID_STALL_CNT_EN
      check("midrst_stall_cnt", BW'(stall_cnt), BW'(0));
`endif
      rst = 1'b0;
      in_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
